// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage with a DEPTH-entry prefetch queue.
//                It reads a combinational instruction memory at fetch_pc,
//                queues {instr, pc} pairs, stops fetching once the halt word
//                is queued, and flushes and refetches on redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int                XLEN      = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0]   HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [XLEN-1:0]            imem_data,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_target,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_instr,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       halted
);

  localparam int                PTR_W      = $clog2(DEPTH);
  localparam int                CNT_W      = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  C_DEPTH    = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] C_PC_STEP  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] C_ALIGN    = ~ADDR_W'(3);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_PEND = 2'd1,
    ST_HALTED    = 2'd2
  } state_t;

  state_t              state_q,    state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]    wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]    count_q,    count_d;
  logic [XLEN-1:0]     instr_q [DEPTH];
  logic [XLEN-1:0]     instr_d [DEPTH];
  logic [ADDR_W-1:0]   pc_q    [DEPTH];
  logic [ADDR_W-1:0]   pc_d    [DEPTH];

  logic                pop;
  logic                push;

  // Output view of the queue head and status; head data is read straight from storage.
  always_comb begin
    imem_addr = fetch_pc_q;
    out_valid = (count_q != '0);
    out_instr = instr_q[rd_ptr_q];
    out_pc    = pc_q[rd_ptr_q];
    occupancy = count_q;
    halted    = (state_q == ST_HALTED);
  end

  // Handshake: a full queue may still accept a fetch when the head leaves the same edge.
  always_comb begin
    pop  = out_valid && out_ready;
    push = (state_q == ST_RUN) && ((count_q != C_DEPTH) || pop);
  end

  // Next-state logic for the queue, fetch PC and halt sequencing; redirect wins over everything.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    instr_d    = instr_q;
    pc_d       = pc_q;

    if (redirect_valid) begin
      // Any pop this edge is simply absorbed by the flush.
      state_d    = ST_RUN;
      fetch_pc_d = redirect_target & C_ALIGN;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        instr_d[wr_ptr_q] = imem_data;
        pc_d[wr_ptr_q]    = fetch_pc_q;
        wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        fetch_pc_d        = fetch_pc_q + C_PC_STEP;
        if (imem_data == HALT_WORD) begin
          state_d = ST_HALT_PEND;
        end
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        // The halt word is always the youngest entry, so it is the head only when it leaves.
        if ((state_q == ST_HALT_PEND) && (out_instr == HALT_WORD)) begin
          state_d = ST_HALTED;
        end
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State and storage registers; reset clears everything including queue contents.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Self-checking bench for fetch_unit: directed scenarios plus
//                randomized ready/redirect traffic against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  // 32-bit address instance
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  occupancy;
  logic        halted;

  // 8-bit address instance for wrap-around
  logic [7:0]  imem_addr8;
  logic [31:0] imem_data8;
  logic        out_valid8;
  logic [31:0] out_instr8;
  logic [7:0]  out_pc8;
  logic [2:0]  occupancy8;
  logic        halted8;

  logic        halt_en   = 1'b0;
  logic [31:0] halt_addr = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  // Instruction memory contents: a pattern that can never equal the halt word.
  function automatic logic [31:0] pat(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (halt_en && (a == halt_addr)) return HALT;
    return pat(a);
  endfunction

  assign imem_data  = mem_word(imem_addr);
  assign imem_data8 = pat({24'h0, imem_addr8});

  always #5 clock = ~clock;

  fetch_unit #(
    .XLEN(32), .ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0), .HALT_WORD(32'hFFFF_FFFF)
  ) u_dut (
    .clock(clock), .reset(reset),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .occupancy(occupancy), .halted(halted)
  );

  fetch_unit #(
    .XLEN(32), .ADDR_W(8), .DEPTH(4), .RESET_PC(8'hFC), .HALT_WORD(32'hFFFF_FFFF)
  ) u_dut8 (
    .clock(clock), .reset(reset),
    .imem_addr(imem_addr8), .imem_data(imem_data8),
    .redirect_valid(1'b0), .redirect_target(8'h00),
    .out_valid(out_valid8), .out_ready(1'b1),
    .out_instr(out_instr8), .out_pc(out_pc8),
    .occupancy(occupancy8), .halted(halted8)
  );

  // Reset for one cycle; returns at a falling edge with reset just released.
  task automatic apply_reset();
    @(negedge clock);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rst_occ: got %0d want 0", occupancy); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b want 0", halted); end
    n_cmp++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", out_instr); end
    n_cmp++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 0", out_pc); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    apply_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_pre_valid: got %b want 0", out_valid); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", k, out_valid); end
      n_cmp++; if (out_pc !== 32'(k * 4)) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h want %h", k, out_pc, 32'(k * 4)); end
      n_cmp++; if (out_instr !== pat(32'(k * 4))) begin n_fail++; $display("FAIL stream_instr[%0d]: got %h want %h", k, out_instr, pat(32'(k * 4))); end
      n_cmp++; if (occupancy !== 3'd1) begin n_fail++; $display("FAIL stream_occ[%0d]: got %0d want 1", k, occupancy); end
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    apply_reset();
    repeat (4) @(negedge clock);
    n_cmp++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL bp_occ_full: got %0d want 4", occupancy); end
    n_cmp++; if (imem_addr !== 32'd16) begin n_fail++; $display("FAIL bp_addr_full: got %0d want 16", imem_addr); end
    @(negedge clock);
    n_cmp++; if (imem_addr !== 32'd16) begin n_fail++; $display("FAIL bp_addr_held: got %0d want 16", imem_addr); end
    n_cmp++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL bp_occ_held: got %0d want 4", occupancy); end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (out_pc !== 32'd0) begin n_fail++; $display("FAIL bp_head: got %0d want 0", out_pc); end
    @(negedge clock);
    n_cmp++; if (imem_addr !== 32'd20) begin n_fail++; $display("FAIL bp_addr_next: got %0d want 20", imem_addr); end
    n_cmp++; if (occupancy !== 3'd4) begin n_fail++; $display("FAIL bp_occ_flow: got %0d want 4", occupancy); end
    n_cmp++; if (out_pc !== 32'd4) begin n_fail++; $display("FAIL bp_head_next: got %0d want 4", out_pc); end
    out_ready = 1'b0;
  endtask

  task automatic test_redirect();
    out_ready = 1'b0;
    apply_reset();
    repeat (3) @(negedge clock);
    n_cmp++; if (occupancy !== 3'd3) begin n_fail++; $display("FAIL rd_occ_pre: got %0d want 3", occupancy); end
    redirect_valid  = 1'b1;
    redirect_target = 32'h43;
    @(negedge clock);
    redirect_valid = 1'b0;
    n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL rd_occ: got %0d want 0", occupancy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rd_valid: got %b want 0", out_valid); end
    n_cmp++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL rd_addr: got %h want 40", imem_addr); end
    @(negedge clock);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rd_valid_after: got %b want 1", out_valid); end
    n_cmp++; if (out_pc !== 32'h40) begin n_fail++; $display("FAIL rd_pc_after: got %h want 40", out_pc); end
    n_cmp++; if (out_instr !== pat(32'h40)) begin n_fail++; $display("FAIL rd_instr_after: got %h want %h", out_instr, pat(32'h40)); end
  endtask

  task automatic test_halt();
    halt_en   = 1'b1;
    halt_addr = 32'd8;
    out_ready = 1'b1;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      n_cmp++; if (out_pc !== 32'(k * 4)) begin n_fail++; $display("FAIL halt_pc[%0d]: got %0d want %0d", k, out_pc, k * 4); end
    end
    n_cmp++; if (out_instr !== HALT) begin n_fail++; $display("FAIL halt_head: got %h want %h", out_instr, HALT); end
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_pend_flag: got %b want 0", halted); end
    n_cmp++; if (imem_addr !== 32'd12) begin n_fail++; $display("FAIL halt_addr_stop: got %0d want 12", imem_addr); end
    repeat (2) @(negedge clock);
    n_cmp++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %b want 1", halted); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL halt_valid: got %b want 0", out_valid); end
    n_cmp++; if (imem_addr !== 32'd12) begin n_fail++; $display("FAIL halt_addr_held: got %0d want 12", imem_addr); end
    redirect_valid  = 1'b1;
    redirect_target = 32'h0;
    @(negedge clock);
    redirect_valid = 1'b0;
    halt_en        = 1'b0;
    n_cmp++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_clear: got %b want 0", halted); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL halt_redir_valid: got %b want 0", out_valid); end
    @(negedge clock);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL halt_restart_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_pc !== 32'd0) begin n_fail++; $display("FAIL halt_restart_pc: got %0d want 0", out_pc); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    apply_reset();
    repeat (2) @(negedge clock);
    n_cmp++; if (occupancy !== 3'd2) begin n_fail++; $display("FAIL ar_occ_pre: got %0d want 2", occupancy); end
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", out_valid); end
    n_cmp++; if (occupancy !== 3'd0) begin n_fail++; $display("FAIL ar_occ: got %0d want 0", occupancy); end
    n_cmp++; if (imem_addr !== 32'd0) begin n_fail++; $display("FAIL ar_addr: got %0d want 0", imem_addr); end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_wrap();
    apply_reset();
    n_cmp++; if (imem_addr8 !== 8'hFC) begin n_fail++; $display("FAIL wrap_addr0: got %h want fc", imem_addr8); end
    @(negedge clock);
    n_cmp++; if (out_pc8 !== 8'hFC) begin n_fail++; $display("FAIL wrap_pc0: got %h want fc", out_pc8); end
    @(negedge clock);
    n_cmp++; if (out_pc8 !== 8'h00) begin n_fail++; $display("FAIL wrap_pc1: got %h want 00", out_pc8); end
    n_cmp++; if (imem_addr8 !== 8'h04) begin n_fail++; $display("FAIL wrap_addr2: got %h want 04", imem_addr8); end
  endtask

  // Random ready/redirect traffic against a queue-level model of the fetch stage.
  task automatic test_random();
    logic [31:0] q_pc[$];
    logic [31:0] q_ins[$];
    logic [31:0] m_fpc;
    logic [31:0] w;
    logic [31:0] h;
    bit          m_pend;
    bit          m_halted;
    bit          pop;
    bit          can_push;
    halt_en   = 1'b1;
    halt_addr = {$urandom_range(4, 40), 2'b00};
    out_ready = 1'b1;
    apply_reset();
    m_fpc    = 32'h0;
    m_pend   = 1'b0;
    m_halted = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      n_cmp++; if (occupancy !== 3'(q_pc.size())) begin n_fail++; $display("FAIL rnd_occ @%0d: got %0d want %0d", cyc, occupancy, q_pc.size()); end
      n_cmp++; if (out_valid !== (q_pc.size() != 0)) begin n_fail++; $display("FAIL rnd_valid @%0d: got %b want %b", cyc, out_valid, q_pc.size() != 0); end
      n_cmp++; if (imem_addr !== m_fpc) begin n_fail++; $display("FAIL rnd_addr @%0d: got %h want %h", cyc, imem_addr, m_fpc); end
      n_cmp++; if (halted !== m_halted) begin n_fail++; $display("FAIL rnd_halted @%0d: got %b want %b", cyc, halted, m_halted); end
      if (q_pc.size() != 0) begin
        n_cmp++; if (out_pc !== q_pc[0]) begin n_fail++; $display("FAIL rnd_pc @%0d: got %h want %h", cyc, out_pc, q_pc[0]); end
        n_cmp++; if (out_instr !== q_ins[0]) begin n_fail++; $display("FAIL rnd_instr @%0d: got %h want %h", cyc, out_instr, q_ins[0]); end
      end

      out_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid  = ($urandom_range(0, 15) == 0);
      redirect_target = $urandom_range(0, 200);

      pop = (q_pc.size() != 0) && out_ready;
      if (redirect_valid) begin
        q_pc.delete();
        q_ins.delete();
        m_fpc    = redirect_target & ~32'd3;
        m_pend   = 1'b0;
        m_halted = 1'b0;
      end else begin
        can_push = !m_pend && !m_halted && ((q_pc.size() < 4) || pop);
        if (pop) begin
          void'(q_pc.pop_front());
          h = q_ins.pop_front();
          if (h == HALT) begin
            m_pend   = 1'b0;
            m_halted = 1'b1;
          end
        end
        if (can_push) begin
          w = mem_word(m_fpc);
          q_pc.push_back(m_fpc);
          q_ins.push_back(w);
          if (w == HALT) m_pend = 1'b1;
          m_fpc = m_fpc + 32'd4;
        end
      end
      @(negedge clock);
    end
    redirect_valid = 1'b0;
    halt_en        = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_async_reset();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
